// File: rtl/comp_signed_4bit_checker_if.sv
// Bus between the signed 4-bit comparator checker and the comparator under test.
// master = checker side, slave = comparator/environment side.
interface comp_signed_4bit_checker_if;
  logic       START;
  logic       A3, A2, A1, A0;
  logic       B3, B2, B1, B0;
  logic       A_GREATER_B, A_LESS_B, A_EQUAL_B;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [8:0] ERR_COUNT;
  logic       FAIL_VALID;
  logic [3:0] FAIL_A;
  logic [3:0] FAIL_B;

  modport master (
    input  START, A_GREATER_B, A_LESS_B, A_EQUAL_B,
    output A3, A2, A1, A0, B3, B2, B1, B0,
    output BUSY, DONE, PASS, ERR_COUNT, FAIL_VALID, FAIL_A, FAIL_B
  );

  modport slave (
    output START, A_GREATER_B, A_LESS_B, A_EQUAL_B,
    input  A3, A2, A1, A0, B3, B2, B1, B0,
    input  BUSY, DONE, PASS, ERR_COUNT, FAIL_VALID, FAIL_A, FAIL_B
  );
endinterface

// File: rtl/comp_signed_4bit_checker.sv
// Exhaustive 256-vector sweep checker for a signed 4-bit magnitude comparator.
// Optional macro COMP_CHECK_HALT_ON_ERR_EN stops the sweep at the first mismatch.
module comp_signed_4bit_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic CLK,
  input  logic RESET,
  comp_signed_4bit_checker_if.master bus
);

  localparam int unsigned IDX_W   = 8;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned ERR_W   = 9;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ERR_MAX = 256;
  localparam int unsigned IDX_MAX = 255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OP_W-1:0]  a_q, b_q;
  logic             busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_q;
  logic             fail_valid_q;
  logic [OP_W-1:0]  fail_a_q, fail_b_q;

  logic [2:0]       exp_c, flags_c;
  logic             mismatch_c;
  logic [ERR_W-1:0] err_inc_c;

  // Expected one-hot {GT, LT, EQ} of the operands currently driven
  always_comb begin
    exp_c      = {($signed(a_q) > $signed(b_q)),
                  ($signed(a_q) < $signed(b_q)),
                  (a_q == b_q)};
    flags_c    = {bus.A_GREATER_B, bus.A_LESS_B, bus.A_EQUAL_B};
    mismatch_c = (flags_c != exp_c);
    err_inc_c  = (err_q == ERR_W'(ERR_MAX)) ? err_q : err_q + ERR_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
    end else begin
      case (state_q)
        IDLE, FINISH: begin
          if (bus.START) begin
            state_q      <= DRIVE;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
          end
        end
        DRIVE: begin
          a_q     <= idx_q[7:4];
          b_q     <= idx_q[3:0];
          cnt_q   <= '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CHECK: begin
          if (mismatch_c) begin
            err_q <= err_inc_c;
            if (!fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_a_q     <= a_q;
              fail_b_q     <= b_q;
            end
          end
`ifdef COMP_CHECK_HALT_ON_ERR_EN
          if (mismatch_c || idx_q == IDX_W'(IDX_MAX)) begin
`else
          if (idx_q == IDX_W'(IDX_MAX)) begin
`endif
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0) && !mismatch_c;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= DRIVE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {bus.A3, bus.A2, bus.A1, bus.A0} = a_q;
  assign {bus.B3, bus.B2, bus.B1, bus.B0} = b_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.PASS       = pass_q;
  assign bus.ERR_COUNT  = err_q;
  assign bus.FAIL_VALID = fail_valid_q;
  assign bus.FAIL_A     = fail_a_q;
  assign bus.FAIL_B     = fail_b_q;

endmodule

// File: tb/tb_comp_signed_4bit_checker.sv
// Bench for comp_signed_4bit_checker: comparator models driven against the checker,
// sweep results compared with a table and with a reference fault model.
module tb_comp_signed_4bit_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  comp_signed_4bit_checker_if bus  ();
  comp_signed_4bit_checker_if bus1 ();
  comp_signed_4bit_checker_if bus3 ();

  comp_signed_4bit_checker #(.SETTLE_CYCLES(2)) u_dut (.CLK(clk), .RESET(rst), .bus(bus));
  comp_signed_4bit_checker #(.SETTLE_CYCLES(1)) u_s1  (.CLK(clk), .RESET(rst), .bus(bus1));
  comp_signed_4bit_checker #(.SETTLE_CYCLES(3)) u_s3  (.CLK(clk), .RESET(rst), .bus(bus3));

  int n_vec = 0;
  int n_err = 0;

  // Reference signed compare, done on plain integers
  function automatic logic [2:0] ref_flags(input logic [3:0] a, input logic [3:0] b);
    int sa, sb;
    sa = int'(a); if (sa > 7) sa = sa - 16;
    sb = int'(b); if (sb > 7) sb = sb - 16;
    return {(sa > sb), (sa < sb), (sa == sb)};
  endfunction

  // Comparator under test for the main instance: 0 ideal, 1 EQ stuck 0, 2 unsigned, 3 fault table
  int         mode;
  logic [2:0] fault_pat [256];
  logic [3:0] opa, opb;
  logic [2:0] flags;
  always_comb begin
    opa = {bus.A3, bus.A2, bus.A1, bus.A0};
    opb = {bus.B3, bus.B2, bus.B1, bus.B0};
    case (mode)
      1:       flags = {ref_flags(opa, opb) & 3'b110};
      2:       flags = {(opa > opb), (opa < opb), (opa == opb)};
      3:       flags = ref_flags(opa, opb) ^ fault_pat[{opa, opb}];
      default: flags = ref_flags(opa, opb);
    endcase
    {bus.A_GREATER_B, bus.A_LESS_B, bus.A_EQUAL_B} = flags;
  end

  // Two-cycle delayed comparators for the settle-time instances
  logic [3:0] a1, b1, a3, b3;
  logic [2:0] p1a, p1b, p3a, p3b;
  assign a1 = {bus1.A3, bus1.A2, bus1.A1, bus1.A0};
  assign b1 = {bus1.B3, bus1.B2, bus1.B1, bus1.B0};
  assign a3 = {bus3.A3, bus3.A2, bus3.A1, bus3.A0};
  assign b3 = {bus3.B3, bus3.B2, bus3.B1, bus3.B0};
  always_ff @(posedge clk) begin
    p1a <= ref_flags(a1, b1);
    p1b <= p1a;
    p3a <= ref_flags(a3, b3);
    p3b <= p3a;
  end
  assign {bus1.A_GREATER_B, bus1.A_LESS_B, bus1.A_EQUAL_B} = p1b;
  assign {bus3.A_GREATER_B, bus3.A_LESS_B, bus3.A_EQUAL_B} = p3b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"},     {28'd0, opa}, 0);
    check({tag, "_b"},     {28'd0, opb}, 0);
    check({tag, "_busy"},  {31'd0, bus.BUSY}, 0);
    check({tag, "_done"},  {31'd0, bus.DONE}, 0);
    check({tag, "_pass"},  {31'd0, bus.PASS}, 0);
    check({tag, "_err"},   {23'd0, bus.ERR_COUNT}, 0);
    check({tag, "_fv"},    {31'd0, bus.FAIL_VALID}, 0);
    check({tag, "_fa"},    {28'd0, bus.FAIL_A}, 0);
    check({tag, "_fb"},    {28'd0, bus.FAIL_B}, 0);
  endtask

  // Pulse START, then count edges until DONE; optional re-pulses while busy
  task automatic sweep(input int p1, input int p2, output int cyc);
    bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
    check("start_busy", {31'd0, bus.BUSY}, 1);
    check("start_done", {31'd0, bus.DONE}, 0);
    check("start_err",  {23'd0, bus.ERR_COUNT}, 0);
    check("start_fv",   {31'd0, bus.FAIL_VALID}, 0);
    cyc = 0;
    while (cyc < 3000 && !bus.DONE) begin
      bus.START = (cyc == p1 || cyc == p2);
      @(posedge clk); #1;
      cyc++;
    end
    bus.START = 1'b0;
  endtask

  typedef struct {
    int mode;
    int dens;
    int err;
    int pass;
    int fv;
    int fa;
    int fb;
    int done;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int cyc, d1, first;
    vec_t e;

    tbl[0] = '{0, 0,   0, 1, 0, 0, 0, 1024};
    tbl[1] = '{1, 0,  16, 0, 1, 0, 0, 1024};
    tbl[2] = '{2, 0, 128, 0, 1, 0, 8, 1024};
    tbl[3] = '{3, 32,  0, 0, 0, 0, 0, 1024};
    tbl[4] = '{3, 1,   0, 0, 0, 0, 0, 1024};

    rst = 1'b1;
    mode = 0;
    bus.START = 1'b0; bus1.START = 1'b0; bus3.START = 1'b0;
    for (int i = 0; i < 256; i++) fault_pat[i] = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < 5; r++) begin
      e = tbl[r];
      mode = e.mode;
      if (e.mode == 3) begin
        // Random fault map: each corrupted vector returns a wrong pattern
        e.err = 0; first = -1;
        for (int i = 0; i < 256; i++) begin
          if ($urandom_range(e.dens - 1, 0) == 0) fault_pat[i] = 3'($urandom_range(7, 1));
          else fault_pat[i] = 3'b000;
          if (fault_pat[i] != 3'b000) begin
            e.err++;
            if (first < 0) first = i;
          end
        end
        e.pass = (e.err == 0);
        e.fv   = (e.err != 0);
        e.fa   = (first < 0) ? 0 : first / 16;
        e.fb   = (first < 0) ? 0 : first % 16;
      end
`ifdef COMP_CHECK_HALT_ON_ERR_EN
      if (e.err > 0) begin
        e.err  = 1;
        e.done = (e.fa * 16 + e.fb + 1) * 4;
      end
`endif
      sweep(-1, -1, cyc);
      check($sformatf("row%0d_cycles", r), cyc, e.done);
      check($sformatf("row%0d_err", r),  {23'd0, bus.ERR_COUNT}, e.err);
      check($sformatf("row%0d_pass", r), {31'd0, bus.PASS}, e.pass);
      check($sformatf("row%0d_fv", r),   {31'd0, bus.FAIL_VALID}, e.fv);
      check($sformatf("row%0d_fa", r),   {28'd0, bus.FAIL_A}, e.fa);
      check($sformatf("row%0d_fb", r),   {28'd0, bus.FAIL_B}, e.fb);
      check($sformatf("row%0d_busy", r), {31'd0, bus.BUSY}, 0);
      check($sformatf("row%0d_lasta", r), {28'd0, opa}, (e.done == 1024) ? 15 : e.fa);
      check($sformatf("row%0d_lastb", r), {28'd0, opb}, (e.done == 1024) ? 15 : e.fb);
    end

    // Restart from FINISH with errors present; re-pulses mid-sweep are ignored
    mode = 0;
    sweep(10, 600, cyc);
    check("restart_cycles", cyc, 1024);
    check("restart_pass", {31'd0, bus.PASS}, 1);
    check("restart_err",  {23'd0, bus.ERR_COUNT}, 0);

    // Reset mid-sweep, with START asserted in the same cycle
    mode = 2;
    bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    rst = 1'b1; bus.START = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.START = 1'b0;
    check_zero("midrst");
    @(posedge clk); #1;
    check("midrst_idle", {31'd0, bus.BUSY}, 0);
    mode = 0;
    sweep(-1, -1, cyc);
    check("midrst_cycles", cyc, 1024);
    check("midrst_pass", {31'd0, bus.PASS}, 1);

    // Settle time shorter and longer than the comparator delay
    bus1.START = 1'b1; bus3.START = 1'b1;
    @(posedge clk); #1;
    bus1.START = 1'b0; bus3.START = 1'b0;
    cyc = 0; d1 = 0;
    while (cyc < 3000 && !bus3.DONE) begin
      @(posedge clk); #1;
      cyc++;
      if (bus1.DONE && d1 == 0) d1 = cyc;
    end
    check("s3_cycles", cyc, 1280);
    check("s3_pass", {31'd0, bus3.PASS}, 1);
    check("s3_err",  {23'd0, bus3.ERR_COUNT}, 0);
    check("s1_done_seen", {31'd0, (d1 != 0)}, 1);
    check("s1_has_err", {31'd0, (bus1.ERR_COUNT != 0)}, 1);
    check("s1_pass", {31'd0, bus1.PASS}, 0);
`ifndef COMP_CHECK_HALT_ON_ERR_EN
    check("s1_cycles", d1, 768);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
